// File: rtl/frame_mode_ctrl.sv
// Debounced button mode select and frame-aligned stream routing from the edge-detection taps to the framer.
// Optional stall watchdog: define FRAME_MODE_CTRL_WATCHDOG_EN.
//   state     | meaning
//   ST_IDLE   | between frames, mode follows the debounced buttons
//   ST_STREAM | frame in progress, mode frozen until its last element
module frame_mode_ctrl #(
  parameter int unsigned width_p            = 1,
  parameter int unsigned packet_len_elems_p = 75684,
  parameter int unsigned debounce_cycles_p  = 250000,
  parameter int unsigned timeout_cycles_p   = 2500000
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [3:1]           button_i,
  input  logic [4*width_p-1:0] src_data_i,
  input  logic [3:0]           src_valid_i,
  output logic [3:0]           src_ready_o,
  output logic [width_p-1:0]   data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [1:0]           mode_o,
  output logic                 frame_done_o,
  output logic [7:0]           frame_count_o,
  output logic [5:1]           led_o
);

  localparam int unsigned cnt_w_lp = $clog2(packet_len_elems_p + 1);
  localparam int unsigned db_w_lp  = (debounce_cycles_p > 1) ? $clog2(debounce_cycles_p) : 1;

  localparam logic [cnt_w_lp-1:0] elem_last_lp = cnt_w_lp'(packet_len_elems_p - 1);
  localparam logic [cnt_w_lp-1:0] elem_one_lp  = cnt_w_lp'(1);
  localparam logic [db_w_lp-1:0]  db_last_lp   = db_w_lp'(debounce_cycles_p - 1);
  localparam logic [db_w_lp-1:0]  db_one_lp    = db_w_lp'(1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  logic [2:0]          sync1_q, sync2_q, samp_q, stable_q;
  logic [db_w_lp-1:0]  db_cnt_q, db_cnt_d;
  logic [1:0]          pend_q, pend_d;

  state_e              state_q;
  logic [1:0]          mode_q;
  logic [cnt_w_lp-1:0] elem_cnt_q;
  logic [7:0]          frame_cnt_q;
  logic                hs;
  logic                last_elem;

  logic [width_p-1:0]  src_slot [4];

  // Counter restarts on any change of the synchronized sample and saturates once accepted.
  always_comb begin
    db_cnt_d = db_cnt_q;
    if (sync2_q != samp_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q != db_last_lp) begin
      db_cnt_d = db_cnt_q + db_one_lp;
    end
  end

  always_comb begin
    pend_d = 2'd3;
    case (stable_q)
      3'b001:  pend_d = 2'd0;
      3'b010:  pend_d = 2'd1;
      3'b100:  pend_d = 2'd2;
      default: pend_d = 2'd3;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      sync1_q  <= 3'b000;
      sync2_q  <= 3'b000;
      samp_q   <= 3'b000;
      db_cnt_q <= '0;
      stable_q <= 3'b000;
      pend_q   <= 2'd3;
    end else begin
      sync1_q  <= button_i;
      sync2_q  <= sync1_q;
      samp_q   <= sync2_q;
      db_cnt_q <= db_cnt_d;
      if ((sync2_q == samp_q) && (db_cnt_d == db_last_lp)) begin
        stable_q <= samp_q;
      end
      pend_q   <= pend_d;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_slot
    assign src_slot[g] = src_data_i[g*width_p +: width_p];
  end

  always_comb begin
    src_ready_o         = 4'b1111;
    src_ready_o[mode_q] = ready_i;
    data_o              = src_slot[mode_q];
    valid_o             = src_valid_i[mode_q];
  end

  assign hs        = valid_o & ready_i;
  // The counter rests at zero in IDLE, so one compare covers single-element frames too.
  assign last_elem = (elem_cnt_q == elem_last_lp);
  assign frame_done_o = reset_i & hs & last_elem;

`ifdef FRAME_MODE_CTRL_WATCHDOG_EN
  localparam int unsigned stall_w_lp = (timeout_cycles_p > 1) ? $clog2(timeout_cycles_p) : 1;
  localparam logic [stall_w_lp-1:0] stall_last_lp = stall_w_lp'(timeout_cycles_p - 1);
  localparam logic [stall_w_lp-1:0] stall_one_lp  = stall_w_lp'(1);

  logic [stall_w_lp-1:0] stall_q;
  logic                  abort_q;
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q     <= ST_IDLE;
      mode_q      <= 2'd3;
      elem_cnt_q  <= '0;
      frame_cnt_q <= 8'd0;
`ifdef FRAME_MODE_CTRL_WATCHDOG_EN
      stall_q     <= '0;
      abort_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (hs) begin
            if (last_elem) begin
              frame_cnt_q <= frame_cnt_q + 8'd1;
              mode_q      <= pend_q;
            end else begin
              // Mode stays as used by this first element so the packet has a single source.
              state_q    <= ST_STREAM;
              elem_cnt_q <= elem_one_lp;
`ifdef FRAME_MODE_CTRL_WATCHDOG_EN
              stall_q    <= '0;
`endif
            end
          end else begin
            mode_q <= pend_q;
          end
        end
        ST_STREAM: begin
          if (hs) begin
`ifdef FRAME_MODE_CTRL_WATCHDOG_EN
            stall_q <= '0;
`endif
            if (last_elem) begin
              state_q     <= ST_IDLE;
              elem_cnt_q  <= '0;
              frame_cnt_q <= frame_cnt_q + 8'd1;
            end else begin
              elem_cnt_q <= elem_cnt_q + elem_one_lp;
            end
          end
`ifdef FRAME_MODE_CTRL_WATCHDOG_EN
          else if (stall_q == stall_last_lp) begin
            state_q    <= ST_IDLE;
            elem_cnt_q <= '0;
            stall_q    <= '0;
            abort_q    <= 1'b1;
          end else begin
            stall_q <= stall_q + stall_one_lp;
          end
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mode_o        = mode_q;
  assign frame_count_o = frame_cnt_q;

`ifdef FRAME_MODE_CTRL_WATCHDOG_EN
  assign led_o = {abort_q, frame_cnt_q[0], (state_q == ST_STREAM), mode_q};
`else
  assign led_o = {frame_cnt_q[1:0], (state_q == ST_STREAM), mode_q};
`endif

endmodule
